// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32 funct3
// access encodings, fault cause codes and the default memory wait limit.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone,
        StErr
    } state_t;

    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    localparam logic [1:0] CauseNone     = 2'b00;
    localparam logic [1:0] CauseMisalign = 2'b01;
    localparam logic [1:0] CauseTimeout  = 2'b10;
    localparam logic [1:0] CauseIllegal  = 2'b11;

    localparam int unsigned MaxWaitDefault = 15;

    // Stores have no unsigned variants, so only the three size codes are legal.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3Byte, F3Half, F3Word: ok = 1'b1;
            F3ByteU, F3HalfU:       ok = !is_store;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe/replication and alignment check for the
// incoming request, and lane select plus sign/zero extension for load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_strb,
    output logic [31:0] st_wdata,
    output logic        misaligned,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] lane;

    always_comb begin
        st_strb    = 4'b1111;
        st_wdata   = st_data;
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << req_off;
                st_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                st_strb    = 4'b0011 << {req_off[1], 1'b0};
                st_wdata   = {2{st_data[15:0]}};
                misaligned = req_off[0];
            end
            default: begin
                st_strb    = 4'b1111;
                st_wdata   = st_data;
                misaligned = |req_off;
            end
        endcase
    end

    always_comb begin
        lane    = ld_rdata >> {ld_off, 3'b000};
        ld_data = lane;
        case (ld_funct3)
            F3Byte:  ld_data = {{24{lane[7]}}, lane[7:0]};
            F3Half:  ld_data = {{16{lane[15]}}, lane[15:0]};
            F3ByteU: ld_data = {24'h0, lane[7:0]};
            F3HalfU: ld_data = {16'h0, lane[15:0]};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: IDLE/WAIT/DONE/ERR handshake FSM between the core and a
// ready-based memory port, with alignment, legality and timeout faults.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MaxWaitDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ULAResult,
    input  logic [31:0] WriteData,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Done,
    output logic        Fault,
    output logic [1:0]  FaultCause
);

    localparam logic [7:0] CntLast = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  f3_q;
    logic        we_q;

    logic        req, illegal, misaligned, capture, load_done;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata, ld_data;

    lsu_align u_align (
        .req_funct3 (funct3),
        .req_off    (ULAResult[1:0]),
        .st_data    (WriteData),
        .st_strb    (st_strb),
        .st_wdata   (st_wdata),
        .misaligned (misaligned),
        .ld_funct3  (f3_q),
        .ld_off     (addr_q[1:0]),
        .ld_rdata   (mem_rdata),
        .ld_data    (ld_data)
    );

    assign req     = MemRead | MemWrite;
    assign illegal = (MemRead & MemWrite) | !f3_legal(funct3, MemWrite);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        capture   = 1'b0;
        load_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    if (illegal) begin
                        cause_d = CauseIllegal;
                        state_d = StErr;
                    end else if (misaligned) begin
                        cause_d = CauseMisalign;
                        state_d = StErr;
                    end else begin
                        capture = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                // A ready on the last permitted cycle still completes the access.
                if (mem_ready) begin
                    load_done = !we_q;
                    state_d   = StDone;
                end else if (cnt_q == CntLast) begin
                    cause_d = CauseTimeout;
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            cause_q <= CauseNone;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'b0000;
            f3_q    <= 3'b000;
            we_q    <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            if (capture) begin
                addr_q  <= ULAResult;
                f3_q    <= funct3;
                we_q    <= MemWrite;
                wdata_q <= st_wdata;
                wstrb_q <= MemWrite ? st_strb : 4'b0000;
            end
            if (load_done) begin
                rdata_q <= ld_data;
            end
        end
    end

    assign mem_req    = (state_q == StWait);
    assign mem_we     = we_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;
    assign ReadData   = rdata_q;
    assign Stall      = ((state_q == StIdle) & req) | (state_q == StWait);
    assign Done       = (state_q == StDone);
    assign Fault      = (state_q == StErr);
    assign FaultCause = Fault ? cause_q : CauseNone;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a transaction-level model queues per-cycle expected
// outputs, one negedge process compares them, and literal checks pin the model.
module tb_lsu;

    localparam int MAXW = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ULAResult, WriteData;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] ReadData;
    logic        Stall, Done, Fault;
    logic [1:0]  FaultCause;

    lsu #(.MAX_WAIT(MAXW)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .ULAResult  (ULAResult),
        .WriteData  (WriteData),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .ReadData   (ReadData),
        .Stall      (Stall),
        .Done       (Done),
        .Fault      (Fault),
        .FaultCause (FaultCause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, req, we, done, fault;
        logic [1:0]  cause;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  wstrb;
    } exp_t;

    exp_t        expq[$];
    int          nchk = 0, nfail = 0;
    int          stall_cnt = 0, req_cnt = 0;
    logic [31:0] last_wdata;
    logic [3:0]  last_wstrb;
    logic        last_we;
    logic [1:0]  last_cause;
    logic [31:0] model_rd = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        stall_cnt += int'(Stall);
        req_cnt   += int'(mem_req);
        if (mem_req) begin
            last_wdata = mem_wdata;
            last_wstrb = mem_wstrb;
            last_we    = mem_we;
        end
        if (Fault) last_cause = FaultCause;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("Stall", 32'(Stall), 32'(e.stall));
            chk("mem_req", 32'(mem_req), 32'(e.req));
            chk("Done", 32'(Done), 32'(e.done));
            chk("Fault", 32'(Fault), 32'(e.fault));
            chk("FaultCause", 32'(FaultCause), 32'(e.cause));
            chk("ReadData", ReadData, e.rdata);
            if (e.req) begin
                chk("mem_we", 32'(mem_we), 32'(e.we));
                chk("mem_addr", mem_addr, e.addr);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
                if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
            end
        end
    end

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] rd);
        logic [31:0] lane, v;
        lane = rd >> (8 * off);
        case (f3)
            3'b000: begin v = lane & 32'hFF;   if (v >= 32'h80)   v = v + 32'hFFFF_FF00; end
            3'b001: begin v = lane & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF_0000; end
            3'b100: v = lane & 32'hFF;
            3'b101: v = lane & 32'hFFFF;
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic exp_t blank();
        exp_t e;
        e.stall = 0; e.req = 0; e.we = 0; e.done = 0; e.fault = 0; e.cause = 2'b00;
        e.addr = 0; e.wdata = 0; e.wstrb = 0; e.rdata = model_rd;
        return e;
    endfunction

    // ready_at: index of the WAIT cycle where mem_ready rises; negative = never.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int ready_at);
        exp_t e;
        int bytes, off;
        logic legal, illegal;
        logic [1:0] cause;
        bytes = 1 << f3[1:0];
        off   = int'(a & 32'h3);
        if (wr) legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        else    legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                         f3 == 3'b100 || f3 == 3'b101);
        illegal = (rd && wr) || !legal;
        cause = illegal ? 2'b11 : ((int'(a) % bytes) != 0) ? 2'b01 : 2'b00;

        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; funct3 = f3; ULAResult = a; WriteData = wd;
        mem_rdata = rdat; mem_ready = 0;
        e = blank(); e.stall = 1; expq.push_back(e);

        if (cause != 2'b00) begin
            @(posedge clk); #1;
            e = blank(); e.fault = 1; e.cause = cause;
        end else begin
            for (int i = 0; i < MAXW; i++) begin
                @(posedge clk); #1;
                MemRead = 0; MemWrite = 0;
                mem_ready = (i == ready_at);
                e = blank(); e.stall = 1; e.req = 1; e.we = wr; e.addr = a & ~32'h3;
                e.wstrb = wr ? 4'(((1 << bytes) - 1) << off) : 4'b0000;
                e.wdata = (bytes == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                          (bytes == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
                expq.push_back(e);
                if (i == ready_at) break;
            end
            @(posedge clk); #1;
            mem_ready = 0;
            if (ready_at >= 0 && ready_at < MAXW) begin
                if (!wr) model_rd = fmt_load(f3, off, rdat);
                e = blank(); e.done = 1;
            end else begin
                e = blank(); e.fault = 1; e.cause = 2'b10;
            end
        end
        // A valid request presented in DONE/ERR must be ignored.
        MemRead = 1; MemWrite = 0; funct3 = 3'b010; ULAResult = 32'h8000;
        expq.push_back(e);
        @(posedge clk); #1;
        MemRead = 0;
        e = blank(); expq.push_back(e);
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        reset = 1; MemRead = 0; MemWrite = 0; funct3 = 0; ULAResult = 0; WriteData = 0;
        mem_rdata = 0; mem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst mem_req", 32'(mem_req), 32'h0);
        chk("rst mem_we", 32'(mem_we), 32'h0);
        chk("rst mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst ReadData", ReadData, 32'h0);
        chk("rst Done/Fault/Cause", {29'h0, Done, Fault, FaultCause == 2'b00}, 32'h1);
        reset = 0;

        // LB 0x1003, ready on second WAIT cycle.
        stall_cnt = 0; req_cnt = 0;
        access(1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 1);
        chk("LB ReadData lit", ReadData, 32'hFFFF_FF80);
        chk("LB stall cycles", 32'(stall_cnt), 32'd3);
        chk("LB req cycles", 32'(req_cnt), 32'd2);

        // SH 0x2002, immediate ready.
        access(0, 1, 3'b001, 32'h2002, 32'h0000_BEEF, 32'h0, 0);
        chk("SH wdata lit", last_wdata, 32'hBEEF_BEEF);
        chk("SH wstrb lit", 32'(last_wstrb), 32'hC);
        chk("SH we lit", 32'(last_we), 32'h1);
        chk("SH keeps ReadData", ReadData, 32'hFFFF_FF80);

        // LW 0x3001 misaligned.
        req_cnt = 0;
        access(1, 0, 3'b010, 32'h3001, 32'h0, 32'h0, 0);
        chk("LW misalign cause", 32'(last_cause), 32'h1);
        chk("LW misalign no req", 32'(req_cnt), 32'd0);

        // LHU 0x4000 timeout.
        req_cnt = 0;
        access(1, 0, 3'b101, 32'h4000, 32'h0, 32'h0, -1);
        chk("timeout req cycles", 32'(req_cnt), 32'd15);
        chk("timeout cause", 32'(last_cause), 32'h2);

        // MemRead and MemWrite together.
        req_cnt = 0;
        access(1, 1, 3'b010, 32'h5000, 32'h0, 32'h0, 0);
        chk("both cause", 32'(last_cause), 32'h3);
        chk("both no req", 32'(req_cnt), 32'd0);

        access(1, 0, 3'b100, 32'h1001, 32'h0, 32'h80FF_1234, 0);
        chk("LBU lit", ReadData, 32'h0000_0012);
        access(1, 0, 3'b001, 32'h1002, 32'h0, 32'h80FF_1234, 2);
        chk("LH lit", ReadData, 32'hFFFF_80FF);
        access(1, 0, 3'b010, 32'h1000, 32'h0, 32'hDEAD_BEEF, MAXW - 1);
        chk("LW ready at limit", ReadData, 32'hDEAD_BEEF);
        access(0, 1, 3'b000, 32'h6001, 32'h0000_00A5, 32'h0, 1);
        chk("SB wstrb lit", 32'(last_wstrb), 32'h2);
        chk("SB wdata lit", last_wdata, 32'hA5A5_A5A5);
        access(0, 1, 3'b010, 32'h7000, 32'h1234_5678, 32'h0, 0);
        access(1, 0, 3'b011, 32'h7000, 32'h0, 32'h0, 0);
        access(0, 1, 3'b100, 32'h7000, 32'h0, 32'h0, 0);
        access(0, 1, 3'b001, 32'h2001, 32'h0, 32'h0, 0);
        access(1, 0, 3'b001, 32'h2003, 32'h0, 32'h0, 0);
        access(1, 0, 3'b000, 32'h9000, 32'h0, 32'h0000_0077, 0);

        // Reset pulsed during WAIT of an SW.
        @(posedge clk); #1;
        MemWrite = 1; funct3 = 3'b010; ULAResult = 32'h5000; WriteData = 32'hCAFE_F00D;
        mem_ready = 0;
        e = blank(); e.stall = 1; expq.push_back(e);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            MemWrite = 0;
            if (i == 3) reset = 1;
            e = blank(); e.stall = 1; e.req = 1; e.we = 1; e.addr = 32'h5000;
            e.wstrb = 4'hF; e.wdata = 32'hCAFE_F00D; expq.push_back(e);
        end
        @(posedge clk); #1;
        reset = 0;
        model_rd = 32'h0;
        e = blank(); expq.push_back(e);
        @(posedge clk); #1;
        e = blank(); expq.push_back(e);
        @(negedge clk); #1;
        chk("post-reset mem_req", 32'(mem_req), 32'h0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter MAX_WAIT, default 15, SHALL set the number of WAIT cycles without mem_ready before a timeout fault (1..255).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 MemRead  input  1  load request from the control unit.
REQ-005 MemWrite  input  1  store request from the control unit.
REQ-006 funct3  input  3  access size/sign (RV32: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-007 ULAResult  input  32  effective byte address from the ALU.
REQ-008 WriteData  input  32  store data (rs2).
REQ-009 mem_req  output  1  memory request valid.
REQ-010 mem_we  output  1  1 = write, 0 = read.
REQ-011 mem_addr  output  32  word-aligned address, i.e. {addr[31:2], 2'b00}.
REQ-012 mem_wdata  output  32  lane-replicated store data.
REQ-013 mem_wstrb  output  4  byte-enable strobes; 0000 on reads.
REQ-014 mem_rdata  input  32  memory read word, valid when mem_ready = 1.
REQ-015 mem_ready  input  1  memory accepts or completes the request this cycle.
REQ-016 ReadData  output  32  formatted load result.
REQ-017 Stall  output  1  hold the PC and pipeline.
REQ-018 Done  output  1  access completed; single-cycle pulse.
REQ-019 Fault  output  1  access aborted; single-cycle pulse.
REQ-020 FaultCause  output  2  01 misaligned, 10 timeout, 11 illegal (MemRead & MemWrite both high, or an undefined funct3).

Function
REQ-021 FSM states SHALL be IDLE, WAIT, DONE and ERR.
REQ-022 IDLE, valid request (exactly one of MemRead/MemWrite, legal funct3, aligned): the LSU SHALL register the address, data, funct3 and direction, then go to WAIT.
REQ-023 Alignment rule: halfword needs addr[0] = 0; word needs addr[1:0] = 00; byte is always aligned.
REQ-024 IDLE, misaligned or illegal request: the LSU SHALL go to ERR with the matching cause latched; mem_req SHALL never assert for that access.
REQ-025 WAIT: mem_req = 1, and mem_addr/mem_we/mem_wdata/mem_wstrb SHALL stay stable until the edge where mem_ready = 1.
REQ-026 WAIT with mem_ready = 1: reads SHALL capture the formatted mem_rdata into ReadData; the FSM SHALL then go to DONE.
REQ-027 WAIT wait counter: resets on entry; when it reaches MAX_WAIT without mem_ready, the FSM SHALL go to ERR with cause 10 and drop mem_req.
REQ-028 mem_ready and timeout in the same cycle: mem_ready SHALL win.
REQ-029 DONE and ERR SHALL each last exactly one cycle, assert Done or Fault respectively, then return to IDLE.
REQ-030 A new request SHALL be accepted only in IDLE; requests in DONE or ERR are ignored.
REQ-031 Stall = (IDLE & (MemRead | MemWrite)) | WAIT; Stall SHALL be low in DONE and ERR so the core advances.
REQ-032 Store lanes:
 - SB: wstrb = 0001 << addr[1:0], wdata = byte replicated ×4.
 - SH: wstrb = 0011 << {addr[1], 0}, wdata = half replicated ×2.
 - SW: wstrb = 1111.
REQ-033 Loads SHALL select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-034 ReadData SHALL hold its value until the next completed load.
REQ-035 Store completion SHALL leave ReadData unchanged.

Reset
REQ-036 On reset: state = IDLE, counter = 0, mem_req = 0, mem_we = 0, mem_wstrb = 0000, mem_addr = 0, mem_wdata = 0, ReadData = 0, Done = 0, Fault = 0, FaultCause = 00.
REQ-037 Reset asserted in WAIT SHALL drop mem_req at that same edge, with no Done or Fault.

Structure
REQ-038 lsu_pkg SHALL hold the state enum, funct3 constants, FaultCause codes and the MAX_WAIT default.
REQ-039 The combinational lane/strobe/extension logic SHALL be a sub-module lsu_align; the FSM and registers stay in lsu.

Verification
REQ-040 LB at 0x1003, mem_rdata 0x80FF_1234 after 2 wait cycles -> mem_addr 0x1000; ReadData 0xFFFF_FF80; Done one cycle; Stall high for 3 cycles.
REQ-041 SH at 0x2002, WriteData 0x0000_BEEF, mem_ready immediate -> mem_wstrb 1100, mem_wdata 0xBEEF_BEEF, mem_we 1.
REQ-042 LW at 0x3001 -> Fault with FaultCause 01 next cycle; mem_req stays 0.
REQ-043 LHU at 0x4000, mem_ready never asserted, MAX_WAIT = 15 -> mem_req high for 15 cycles, then Fault with FaultCause 10.
REQ-044 Reset pulsed during WAIT of an SW -> mem_req 0 at that edge; state IDLE; no Done.
REQ-045 MemRead = MemWrite = 1 -> FaultCause 11; no memory access.
